// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Receive-side VGA timing checker. Samples active-low hsync/vsync and display-enable on
//   pixel-rate enables and recovers the active-area pixel coordinates. It also measures
//   line length and frame height, and runs a lock state machine against H_TOTAL/V_TOTAL.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   pix_en          pixel-rate enable; all sampling/counting is gated by it
//   vga_h_sync      horizontal sync, active low
//   vga_v_sync      vertical sync, active low
//   de              display enable, active high
//   pix_x, pix_y    active-area column/row, one pix_en behind the inputs
//   pix_valid       registered de
//   line_len        last measured pixels per line (hsync assertion to assertion)
//   frame_lines     last measured lines per frame (frame boundary to frame boundary)
//   locked          timing matches H_TOTAL/V_TOTAL for LOCK_FRAMES consecutive frames
//   err             one-clock pulse on a timing mismatch while measuring or locked
//   err_cnt         saturating count of err pulses
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL     = 768,
  parameter int unsigned V_TOTAL     = 512,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned CNT_W       = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  input  logic             vga_h_sync,
  input  logic             vga_v_sync,
  input  logic             de,
  output logic [9:0]       pix_x,
  output logic [8:0]       pix_y,
  output logic             pix_valid,
  output logic [CNT_W-1:0] line_len,
  output logic [CNT_W-1:0] frame_lines,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] HTot   = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] VTot   = CNT_W'(V_TOTAL);
  localparam int unsigned      GoodW  = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

  state_e           state_q;
  logic [GoodW-1:0] good_q;
  logic             bad_q;     // a bad line was seen in the frame being measured

  logic             hs_q, vs_q;
  logic [CNT_W-1:0] h_cnt_q, v_cnt_q;
  logic             v_pend_q;  // vsync asserted, waiting for the next hsync to close the frame

  logic             h_edge, v_edge, fb, h_timeout;
  logic [CNT_W-1:0] h_cnt_inc, v_cnt_inc;
  logic             line_bad, frame_ok, err_ev;

  // Event decode; everything is qualified by pix_en here so the state logic need not be.
  always_comb begin
    h_edge    = pix_en & hs_q & ~vga_h_sync;
    v_edge    = pix_en & vs_q & ~vga_v_sync;
    fb        = h_edge & (v_pend_q | v_edge);
    h_cnt_inc = (h_cnt_q == CntMax) ? CntMax : h_cnt_q + 1'b1;
    v_cnt_inc = (v_cnt_q == CntMax) ? CntMax : v_cnt_q + 1'b1;
    h_timeout = pix_en & ~h_edge & (h_cnt_q == CntMax);
    // h_cnt_inc / v_cnt_inc are the values about to be latched into line_len / frame_lines
    line_bad  = h_edge & (h_cnt_inc != HTot);
    frame_ok  = (v_cnt_inc == VTot);
  end

  // At most one err per cycle: all mismatch sources are merged into a single event.
  always_comb begin
    err_ev = 1'b0;
    unique case (state_q)
      StMeasure: err_ev = line_bad | (fb & ~(frame_ok & ~bad_q));
      StLocked:  err_ev = line_bad | (fb & ~frame_ok) | h_timeout;
      default:   err_ev = 1'b0;
    endcase
  end

  // Sync edge detection and line/frame measurement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      v_pend_q    <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
    end else if (pix_en) begin
      hs_q <= vga_h_sync;
      vs_q <= vga_v_sync;
      if (h_edge) begin
        line_len <= h_cnt_inc;
        h_cnt_q  <= '0;
      end else begin
        h_cnt_q <= h_cnt_inc;
      end
      if (fb) begin
        // A vsync coincident with hsync closes the frame here without counting an extra line.
        frame_lines <= v_cnt_inc;
        v_cnt_q     <= '0;
        v_pend_q    <= 1'b0;
      end else begin
        if (h_edge) v_cnt_q <= v_cnt_inc;
        if (v_edge) v_pend_q <= 1'b1;
      end
    end
  end

  // Active-area coordinates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
    end else if (pix_en) begin
      pix_valid <= de;
      if (de && pix_valid) pix_x <= pix_x + 10'd1;
      else                 pix_x <= '0;
      if (v_edge)                  pix_y <= '0;
      else if (pix_valid && !de)   pix_y <= pix_y + 9'd1;
    end
  end

  // Lock state machine with registered locked/err/err_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StSearch;
      good_q  <= '0;
      bad_q   <= 1'b0;
      locked  <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      err <= err_ev;
      if (err_ev && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
      if (pix_en) begin
        unique case (state_q)
          StSearch: begin
            if (fb) begin
              state_q <= StMeasure;
              good_q  <= '0;
              bad_q   <= 1'b0;
            end
          end
          StMeasure: begin
            if (fb) begin
              bad_q <= 1'b0;
              if (frame_ok && !bad_q && !line_bad) begin
                if (32'(good_q) + 32'd1 >= LOCK_FRAMES) begin
                  state_q <= StLocked;
                  locked  <= 1'b1;
                  good_q  <= '0;
                end else begin
                  good_q <= good_q + 1'b1;
                end
              end else begin
                good_q <= '0;
              end
            end else if (line_bad) begin
              bad_q  <= 1'b1;
              good_q <= '0;
            end
          end
          StLocked: begin
            if (line_bad || (fb && !frame_ok)) begin
              state_q <= StMeasure;
              locked  <= 1'b0;
              good_q  <= '0;
              bad_q   <= 1'b0;
            end
          end
          default: state_q <= StSearch;
        endcase
        // Missing hsync overrides everything: drop back to searching.
        if (h_timeout) begin
          state_q <= StSearch;
          locked  <= 1'b0;
        end
      end
    end
  end

endmodule
